// File: rtl/noc_pkg.sv
// Shared NoC types: flit type encoding and the flit-type field layout.
// Pure declarations, no logic.
// Not applicable.
package noc_pkg;

    localparam int NOC_FLIT_WIDTH = 34;
    localparam int FTYPE_W        = 2;

    typedef enum logic [FTYPE_W-1:0] {
        FT_HEAD      = 2'b00,
        FT_BODY      = 2'b01,
        FT_TAIL      = 2'b10,
        FT_HEAD_TAIL = 2'b11
    } flit_type_t;

    function automatic logic opens_pkt(input flit_type_t t);
        return (t == FT_HEAD) || (t == FT_HEAD_TAIL);
    endfunction

endpackage

// File: rtl/vc_input_buffer_if.sv
// Link-side and crossbar-side handshake bundle of the VC input buffer.
// Wires only, no latency.
// Backpressure carried by ready_o (link side) and ready_i (crossbar side).
interface vc_input_buffer_if #(
    parameter int FLIT_WIDTH = 34,
    parameter int N_VIRT_CHN = 4,
    parameter int BUF_DEPTH  = 4
);
    localparam int VC_W   = $clog2(N_VIRT_CHN);
    localparam int OCUP_W = $clog2(BUF_DEPTH) + 1;

    logic [VC_W-1:0]              vc_id_i;
    logic [FLIT_WIDTH-1:0]        fdata_i;
    logic                         valid_i;
    logic                         ready_o;
    logic [VC_W-1:0]              vc_id_o;
    logic [FLIT_WIDTH-1:0]        fdata_o;
    logic                         valid_o;
    logic                         ready_i;
    logic [N_VIRT_CHN*OCUP_W-1:0] ocup_o;
    logic [N_VIRT_CHN-1:0]        lock_o;
    logic                         err_o;

    modport slave (
        input  vc_id_i, fdata_i, valid_i, ready_i,
        output ready_o, vc_id_o, fdata_o, valid_o, ocup_o, lock_o, err_o
    );

    modport master (
        output vc_id_i, fdata_i, valid_i, ready_i,
        input  ready_o, vc_id_o, fdata_o, valid_o, ocup_o, lock_o, err_o
    );

endinterface

// File: rtl/vc_fifo.sv
// Generic synchronous FIFO with full/empty flags and registered occupancy.
// One cycle write-to-read latency, no bypass.
// Caller must not push when full nor pop when empty.
module vc_fifo #(
    parameter  int WIDTH  = 34,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int OCUP_W = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_dat,
    input  logic              pop,
    output logic [WIDTH-1:0]  pop_dat,
    output logic              full,
    output logic              empty,
    output logic [OCUP_W-1:0] ocup
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [OCUP_W-1:0] wptr, rptr;
    logic [OCUP_W-1:0] wptr_nxt, rptr_nxt;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign wptr_nxt = wptr + OCUP_W'(push);
    assign rptr_nxt = rptr + OCUP_W'(pop);
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_dat  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            ocup <= '0;
        end else begin
            wptr <= wptr_nxt;
            rptr <= rptr_nxt;
            ocup <= wptr_nxt - rptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/vc_input_buffer.sv
// Multi-VC router input buffer: per-VC FIFOs, packet locks, round-robin output arbiter.
// One cycle from accepted flit to earliest presentation on the output.
// ready_o drops on full target VC or HEAD to locked VC; grant held while ready_i is low.
module vc_input_buffer #(
    parameter  int FLIT_WIDTH = 34,
    parameter  int N_VIRT_CHN = 4,
    parameter  int BUF_DEPTH  = 4,
    localparam int VC_W       = $clog2(N_VIRT_CHN),
    localparam int OCUP_W     = $clog2(BUF_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                arst,
    vc_input_buffer_if.slave    bus
);
    import noc_pkg::*;

    logic [N_VIRT_CHN-1:0]  full, empty, push, pop;
    logic [FLIT_WIDTH-1:0]  pop_dat [N_VIRT_CHN];
    logic [OCUP_W-1:0]      ocup    [N_VIRT_CHN];

    logic [N_VIRT_CHN-1:0]  lock, lock_nxt;
    logic                   err, err_nxt;
    logic [VC_W-1:0]        rr_ptr, gnt, gnt_q;
    logic                   hold_q, found;
    logic [FLIT_WIDTH-1:0]  sel_dat;

    flit_type_t             in_type;
    logic                   vc_ok, tgt_full, tgt_lock, accept;

    assign in_type = flit_type_t'(bus.fdata_i[FLIT_WIDTH-1 -: FTYPE_W]);

    // An id that cannot name a VC only exists when N_VIRT_CHN is not a power of two.
    if ((1 << VC_W) == N_VIRT_CHN) begin : g_vc_pow2
        assign vc_ok = 1'b1;
    end else begin : g_vc_range
        assign vc_ok = (32'(bus.vc_id_i) < N_VIRT_CHN);
    end

    always_comb begin
        tgt_full = 1'b1;
        tgt_lock = 1'b0;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            if (bus.vc_id_i == VC_W'(v)) begin
                tgt_full = full[v];
                tgt_lock = lock[v];
            end
        end
    end

    assign bus.ready_o = vc_ok & ~tgt_full & ~(opens_pkt(in_type) & tgt_lock);
    assign accept      = bus.valid_i & bus.ready_o & ~arst;

    always_comb begin
        lock_nxt = lock;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            if (accept && bus.vc_id_i == VC_W'(v)) begin
                if (in_type == FT_HEAD) lock_nxt[v] = 1'b1;
                if (in_type == FT_TAIL) lock_nxt[v] = 1'b0;
            end
        end
        err_nxt = (bus.valid_i & ~vc_ok)
                | (accept & ((in_type == FT_BODY) | (in_type == FT_TAIL)) & ~tgt_lock);
    end

    // Round-robin search from rr_ptr; a stalled grant is replayed unchanged.
    always_comb begin : p_arb
        int idx;
        idx   = 0;
        gnt   = gnt_q;
        found = 1'b0;
        if (hold_q) begin
            found = 1'b1;
        end else begin
            for (int i = 0; i < N_VIRT_CHN; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= N_VIRT_CHN) idx = idx - N_VIRT_CHN;
                if (!found && !empty[idx]) begin
                    found = 1'b1;
                    gnt   = VC_W'(idx);
                end
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            if (gnt == VC_W'(v)) sel_dat = pop_dat[v];
        end
    end

    assign bus.valid_o = found;
    assign bus.vc_id_o = found ? gnt : '0;
    assign bus.fdata_o = found ? sel_dat : '0;
    assign bus.lock_o  = lock;
    assign bus.err_o   = err;

    for (genvar v = 0; v < N_VIRT_CHN; v++) begin : g_vc
        assign push[v] = accept & (bus.vc_id_i == VC_W'(v));
        assign pop[v]  = found & bus.ready_i & (gnt == VC_W'(v)) & ~arst;

        vc_fifo #(
            .WIDTH (FLIT_WIDTH),
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (arst),
            .push     (push[v]),
            .push_dat (bus.fdata_i),
            .pop      (pop[v]),
            .pop_dat  (pop_dat[v]),
            .full     (full[v]),
            .empty    (empty[v]),
            .ocup     (ocup[v])
        );

        assign bus.ocup_o[v*OCUP_W +: OCUP_W] = ocup[v];
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            lock   <= '0;
            err    <= 1'b0;
            rr_ptr <= '0;
            gnt_q  <= '0;
            hold_q <= 1'b0;
        end else begin
            lock   <= lock_nxt;
            err    <= err_nxt;
            gnt_q  <= gnt;
            hold_q <= found & ~bus.ready_i;
            if (found && bus.ready_i) begin
                rr_ptr <= (gnt == VC_W'(N_VIRT_CHN - 1)) ? '0 : gnt + VC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Randomized bench for vc_input_buffer against a queue-based packet model.
// Directed scenarios first, then a long random run with occasional resets.
module tb_vc_input_buffer;

    localparam int FW    = 34;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int VW    = $clog2(N);
    localparam int OW    = $clog2(DEPTH) + 1;

    localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HT = 2'b11;

    logic clk;
    logic arst;

    vc_input_buffer_if #(.FLIT_WIDTH(FW), .N_VIRT_CHN(N), .BUF_DEPTH(DEPTH)) bus ();

    vc_input_buffer #(.FLIT_WIDTH(FW), .N_VIRT_CHN(N), .BUF_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: stored flits per VC, open-packet flags, fairness pointer.
    logic [FW-1:0] mq [N][$];
    bit            m_lock [N];
    int            m_rr;
    bit            m_hold;
    int            m_gnt;
    bit            m_err;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h want %0h", tag, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < N; v++) begin
            mq[v].delete();
            m_lock[v] = 1'b0;
        end
        m_rr   = 0;
        m_hold = 1'b0;
        m_gnt  = 0;
        m_err  = 1'b0;
    endtask

    // One clock: drive after the edge, check mid-cycle, advance the model, wait for the edge.
    task automatic step(input bit rst, input bit v, input int vc, input logic [1:0] ft,
                        input logic [31:0] pl, input bit rdy);
        logic [FW-1:0]     fl;
        logic [N*OW-1:0]   e_ocup;
        logic [N-1:0]      e_lock;
        int                g;
        bit                e_rdy, e_vld, acc, opens;
        #1;
        fl           = {ft, pl};
        arst         = rst;
        bus.valid_i  = v;
        bus.vc_id_i  = VW'(vc);
        bus.fdata_i  = fl;
        bus.ready_i  = rdy;
        #2;
        opens = (ft == HEAD) || (ft == HT);
        e_rdy = (mq[vc].size() < DEPTH) && !(opens && m_lock[vc]);
        g = -1;
        if (m_hold) g = m_gnt;
        else begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && mq[(m_rr + i) % N].size() != 0) g = (m_rr + i) % N;
            end
        end
        e_vld = (g >= 0);
        for (int k = 0; k < N; k++) begin
            e_ocup[k*OW +: OW] = OW'(mq[k].size());
            e_lock[k]          = m_lock[k];
        end
        chk("ready_o", 64'(bus.ready_o), 64'(e_rdy));
        chk("valid_o", 64'(bus.valid_o), 64'(e_vld));
        chk("vc_id_o", 64'(bus.vc_id_o), e_vld ? 64'(g) : 64'(0));
        chk("fdata_o", 64'(bus.fdata_o), e_vld ? 64'(mq[g][0]) : 64'(0));
        chk("ocup_o",  64'(bus.ocup_o),  64'(e_ocup));
        chk("lock_o",  64'(bus.lock_o),  64'(e_lock));
        chk("err_o",   64'(bus.err_o),   64'(m_err));
        if (rst) begin
            model_clear();
        end else begin
            acc   = v && e_rdy;
            m_err = acc && (ft == BODY || ft == TAIL) && !m_lock[vc];
            if (e_vld && rdy) begin
                void'(mq[g].pop_front());
                m_rr = (g + 1) % N;
            end
            if (acc) begin
                mq[vc].push_back(fl);
                if (ft == HEAD) m_lock[vc] = 1'b1;
                if (ft == TAIL) m_lock[vc] = 1'b0;
            end
            m_hold = e_vld && !rdy;
            m_gnt  = g;
        end
        @(posedge clk);
    endtask

    task automatic idle(input bit rdy, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 0, HEAD, 32'h0, rdy);
    endtask

    initial begin
        logic [1:0] ft;
        int         vc;
        arst        = 1'b1;
        bus.valid_i = 1'b0;
        bus.vc_id_i = '0;
        bus.fdata_i = '0;
        bus.ready_i = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);

        // Idle after reset
        idle(1'b1, 2);

        // Three-flit packet through VC2 with the output open
        step(1'b0, 1'b1, 2, HEAD, 32'h1, 1'b1);
        step(1'b0, 1'b1, 2, BODY, 32'h2, 1'b1);
        step(1'b0, 1'b1, 2, TAIL, 32'h3, 1'b1);
        idle(1'b1, 3);

        // Fill VC1 while stalled, fifth flit refused, one pop frees a slot
        step(1'b0, 1'b1, 1, HEAD, 32'h10, 1'b0);
        for (int i = 1; i < 5; i++) step(1'b0, 1'b1, 1, BODY, 32'h10 + i, 1'b0);
        idle(1'b1, 1);
        step(1'b0, 1'b1, 1, TAIL, 32'h1f, 1'b0);
        idle(1'b1, 6);

        // VC0 and VC3 contending
        step(1'b0, 1'b1, 0, HT, 32'h20, 1'b0);
        step(1'b0, 1'b1, 0, HT, 32'h21, 1'b0);
        step(1'b0, 1'b1, 3, HT, 32'h30, 1'b0);
        step(1'b0, 1'b1, 3, HT, 32'h31, 1'b0);
        idle(1'b1, 6);

        // HEAD into a locked VC, BODY into an unlocked VC
        step(1'b0, 1'b1, 1, HEAD, 32'h40, 1'b0);
        step(1'b0, 1'b1, 1, HEAD, 32'h41, 1'b0);
        step(1'b0, 1'b1, 0, BODY, 32'h42, 1'b0);
        idle(1'b0, 1);
        step(1'b0, 1'b1, 1, TAIL, 32'h43, 1'b1);
        idle(1'b1, 5);

        // Reset with flits stored
        step(1'b0, 1'b1, 2, HEAD, 32'h50, 1'b0);
        step(1'b0, 1'b1, 2, BODY, 32'h51, 1'b0);
        step(1'b0, 1'b1, 3, HT,   32'h52, 1'b0);
        step(1'b1, 1'b1, 3, HT,   32'h53, 1'b1);
        idle(1'b1, 2);

        // Random traffic, mostly well-formed packets
        for (int c = 0; c < 4000; c++) begin
            vc = $urandom_range(0, N - 1);
            if ($urandom_range(0, 9) == 0) ft = 2'($urandom_range(0, 3));
            else if (m_lock[vc])           ft = ($urandom_range(0, 2) == 0) ? TAIL : BODY;
            else                           ft = ($urandom_range(0, 1) == 0) ? HEAD : HT;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, vc, ft,
                 $urandom, $urandom_range(0, 9) < 6);
        end
        idle(1'b1, 2 * N * DEPTH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
